result_bcd_display: RTL
=======================

# result_bcd_display

Downstream stage of the registered calculator. It captures the registered 2N-bit result and the 4-bit flags on a start strobe, and converts the result to packed BCD with a sequential shift-add-3 (double-dabble) engine. It then drives one active-low 7-segment pattern per digit for the board display. Outputs hold the last completed conversion until the next one finishes, so the display never shows intermediate values.

## Interface
- N, default 8: calculator operand width; the result input is 2N bits.
- DIGITS, default 5: number of BCD digits; must satisfy 10^DIGITS > 2^(2N). The default covers 65535.
- clk, input, 1: single system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- result, input, 2N: registered calculator result.
- flags, input, 4: registered calculator flags.
- start, input, 1: one-cycle request to capture and convert.
- busy, output, 1: high from the cycle after an accepted start until done.
- done, output, 1: one-cycle pulse when new outputs are valid.
- bcd, output, 4*DIGITS: packed BCD. Digit 0 (units) is in bits [3:0].
- seg, output, 7*DIGITS: active-low segments {g,f,e,d,c,b,a} per digit. Digit 0 is in bits [6:0].
- flags_q, output, 4: flags captured with the displayed result.
- neg, output, 1: sign of the displayed value. Tied to 0 unless SIGNED_DISPLAY_EN is defined.

## Operation
- The FSM has three states: IDLE, CONVERT and DONE.
- IDLE with start=1:
  - Capture the magnitude of result into the shift register.
  - Capture flags into a pending register.
  - Clear the BCD scratch register and set bit counter = 0.
  - Go to CONVERT.
- start is ignored outside IDLE. It has no effect and does not queue.
- CONVERT, each cycle:
  - Every scratch nibble ≥ 5 gets +3.
  - Then {scratch, shift} shifts left by 1.
  - The counter increments. When the counter reaches 2N-1 on this shift, go to DONE.
- DONE, one cycle:
  - Copy scratch to bcd, pending flags to flags_q, and pending sign to neg.
  - Pulse done=1 and return to IDLE.
- seg is a combinational decode of the registered bcd. No leading-zero blanking.
- Digit codes 10-15 cannot occur. The decoder still maps them to all segments off (7'h7F).
- Width rules:
  - The shift register is 2N bits and the scratch register is 4*DIGITS bits.
  - Add-3 is performed per nibble without carry into the neighbouring nibble.

## Timing
- Start accepted at edge k:
  - busy=1 from k+1 through k+2N.
  - The last shift occurs at edge k+2N.
  - done=1 and the new bcd/seg/flags_q/neg appear after edge k+2N+1.
  - Total latency is 2N+1 cycles; 17 for N=8.
- done and busy are never high in the same cycle.
- A new start is accepted the cycle after done.
- Reset values:
  - bcd=0 and flags_q=0.
  - seg = 7'h40 for every digit, which displays "0".
  - busy=0, done=0, neg=0.
  - FSM in IDLE; counter, scratch and shift all 0.
- Reset mid-conversion aborts immediately. The partial result is discarded and the outputs return to their reset values.

## Configuration
- Macro: SIGNED_DISPLAY_EN.
- When defined:
  - result is treated as two's complement.
  - If result[2N-1]=1, the captured magnitude is the 2N-bit negation, and the pending sign = 1.
  - The most negative value, -2^(2N-1), converts to its unsigned magnitude.
- When undefined:
  - result is unsigned and the magnitude equals result.
  - neg is constantly 0.

## Structure
- Package calc_display_pkg holds:
  - The state enum (IDLE, CONVERT, DONE).
  - SEG_BLANK = 7'h7F.
  - The 16-entry digit-to-segment constant table.
- Sub-module bcd_to_seg7: combinational 4-bit to 7-bit active-low decoder, instantiated DIGITS times by a generate loop.

## Test plan
- Reset: assert reset with no clock edge -> bcd=0, seg=all 7'h40, busy=0, done=0, flags_q=0.
- Basic conversion: result=16'd12345, flags=4'b0010, one-cycle start -> busy for 16 cycles, done on the 17th cycle, bcd=20'h12345, flags_q=4'b0010.
- Maximum value: result=16'hFFFF -> bcd=20'h65535.
- Digit patterns: digit 5 gives seg 7'h12 and digit 6 gives seg 7'h02.
- Start while busy: a second start at cycle 5 with result=16'd7 is ignored -> the single done shows the first value, and bcd updates only once.
- Signed mode: result=16'hFF85 -> with SIGNED_DISPLAY_EN, bcd=20'h00123 and neg=1; without the macro, bcd=20'h65413 and neg=0.
- Reset mid-conversion: assert reset at cycle 5 of CONVERT -> busy=0, no done pulse, outputs at reset values. A following start with result=16'd42 gives bcd=20'h00042 after 17 cycles.

Source files
------------

// File: rtl/calc_display_pkg.sv
// Shared types and constants for the calculator result display stage.
package calc_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        SEG_BLANK, SEG_BLANK
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment decoder.
module bcd_to_seg7
    import calc_display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/result_bcd_display.sv
// Captures the calculator result and flags, converts the result to BCD with a
// sequential double-dabble engine and drives 7-segment digits. Optional macro: SIGNED_DISPLAY_EN.
module result_bcd_display
    import calc_display_pkg::*;
#(
    parameter int N      = 8,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2*N-1:0]        result,
    input  logic [3:0]            flags,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic [3:0]            flags_q,
    output logic                  neg
);

    localparam int SW = 2 * N;
    localparam int BW = 4 * DIGITS;
    localparam int CW = (SW > 1) ? $clog2(SW) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(SW - 1);

    state_e          state_q, state_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic [BW-1:0]   scratch_q, scratch_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      flags_pend_q, flags_pend_d;
    logic [3:0]      flags_disp_q, flags_disp_d;
    logic            busy_q, done_q;
    logic [SW-1:0]   mag;
    logic [BW-1:0]   adj;

`ifdef SIGNED_DISPLAY_EN
    logic sign;
    logic sign_pend_q;
    logic neg_q;

    assign sign = result[SW-1];
    // Two's-complement negation; the most negative value maps to its own bit pattern, read unsigned.
    assign mag  = sign ? (~result + SW'(1)) : result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_pend_q <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            if (state_q == IDLE && start) sign_pend_q <= sign;
            if (state_q == DONE)          neg_q       <= sign_pend_q;
        end
    end

    assign neg = neg_q;
`else
    assign mag = result;
    assign neg = 1'b0;
`endif

    // Add-3 on each nibble independently; values 5..9 stay within 4 bits.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        shift_d      = shift_q;
        scratch_d    = scratch_q;
        cnt_d        = cnt_q;
        flags_pend_d = flags_pend_q;
        bcd_d        = bcd_q;
        flags_disp_d = flags_disp_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d      = mag;
                    flags_pend_d = flags;
                    scratch_d    = '0;
                    cnt_d        = '0;
                    state_d      = CONVERT;
                end
            end
            CONVERT: begin
                {scratch_d, shift_d} = {adj, shift_q} << 1;
                cnt_d                = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) state_d = DONE;
            end
            DONE: begin
                bcd_d        = scratch_q;
                flags_disp_d = flags_pend_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q      <= IDLE;
            shift_q      <= '0;
            scratch_q    <= '0;
            cnt_q        <= '0;
            flags_pend_q <= '0;
            bcd_q        <= '0;
            flags_disp_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            scratch_q    <= scratch_d;
            cnt_q        <= cnt_d;
            flags_pend_q <= flags_pend_d;
            bcd_q        <= bcd_d;
            flags_disp_q <= flags_disp_d;
            busy_q       <= (state_q == CONVERT);
            done_q       <= (state_q == DONE);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd     = bcd_q;
    assign flags_q = flags_disp_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_to_seg7 u_dec (
            .digit_i (bcd_q[4*g +: 4]),
            .seg_o   (seg[7*g +: 7])
        );
    end

endmodule
